// File: rtl/fifo_gray_sync_pkg.sv
// Shared helpers for Gray-pointer synchronisers.
// Both the write-side and read-side instances import this package.
package fifo_gray_sync_pkg;

    // Supported synchroniser depths.
    localparam int NUM_STAGES_MIN = 2;
    localparam int NUM_STAGES_MAX = 4;

    // Widest pointer the helper functions handle; narrower pointers are zero-extended.
    localparam int PTR_WIDTH_MAX = 32;

    // Valid counter only needs to reach the deepest legal chain.
    localparam int VALID_CNT_W = $clog2(NUM_STAGES_MAX + 1);

    typedef logic [PTR_WIDTH_MAX-1:0] ptrWord_t;

    // Gray to binary: leading zero Gray bits map to leading zero binary bits,
    // so a zero-extended narrow pointer converts correctly.
    function automatic ptrWord_t grayToBin(input ptrWord_t gray);
        ptrWord_t bin;
        bin[PTR_WIDTH_MAX-1] = gray[PTR_WIDTH_MAX-1];
        for (int i = PTR_WIDTH_MAX - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

    // Number of set bits; used as the Hamming distance between two Gray samples.
    function automatic int unsigned popCount(input ptrWord_t value);
        int unsigned count;
        count = 0;
        for (int i = 0; i < PTR_WIDTH_MAX; i++) begin
            if (value[i]) begin
                count++;
            end
        end
        return count;
    endfunction

endpackage

// File: rtl/fifo_gray_sync_gray_to_bin.sv
// Purely combinational Gray-to-binary converter of configurable width.
module gray_to_bin
    import fifo_gray_sync_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    assign bin_o = WIDTH'(grayToBin(PTR_WIDTH_MAX'(gray_i)));

endmodule

// File: rtl/fifo_gray_sync.sv
// Synchronises a Gray-coded FIFO pointer into the CLK domain, provides its
// registered binary value, a change pulse, a valid flag and a sticky flag
// for illegal multi-bit Gray steps.
module fifo_gray_sync
    import fifo_gray_sync_pkg::*;
#(
    parameter int NUM_STAGES   = 2,
    parameter int PTR_WIDTH    = 4,
    parameter bit ERR_CHECK_EN = 1'b1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [PTR_WIDTH-1:0] ASYNC_GRAY,
    input  logic                 ERR_CLR,
    output logic [PTR_WIDTH-1:0] SYNC_GRAY,
    output logic [PTR_WIDTH-1:0] SYNC_BIN,
    output logic                 SYNC_VALID,
    output logic                 PTR_CHG,
    output logic                 GRAY_ERR
);

    // Out-of-range depths are clamped to the supported range.
    localparam int STAGES = (NUM_STAGES < NUM_STAGES_MIN) ? NUM_STAGES_MIN :
                            (NUM_STAGES > NUM_STAGES_MAX) ? NUM_STAGES_MAX : NUM_STAGES;

    logic [PTR_WIDTH-1:0]   syncStages_q [STAGES];
    logic [PTR_WIDTH-1:0]   syncBin_d;
    logic [PTR_WIDTH-1:0]   syncBin_q;
    logic [PTR_WIDTH-1:0]   prevGray_q;
    logic                   ptrChg_d;
    logic                   ptrChg_q;
    logic [VALID_CNT_W-1:0] validCnt_q;
    logic                   syncValid_q;

    // Per-bit synchroniser chains; each bit is a plain shift with no cross-bit logic.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int s = 0; s < STAGES; s++) begin
                syncStages_q[s] <= '0;
            end
        end else begin
            syncStages_q[0] <= ASYNC_GRAY;
            for (int s = 1; s < STAGES; s++) begin
                syncStages_q[s] <= syncStages_q[s-1];
            end
        end
    end

    assign SYNC_GRAY = syncStages_q[STAGES-1];

    gray_to_bin #(
        .WIDTH(PTR_WIDTH)
    ) grayToBinInst (
        .gray_i(SYNC_GRAY),
        .bin_o (syncBin_d)
    );

    // A change is only reported once the pipeline holds post-reset samples.
    always_comb begin
        ptrChg_d = syncValid_q && (SYNC_GRAY != prevGray_q);
    end

    // Binary output, previous Gray sample and change pulse all align on the same edge.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            syncBin_q  <= '0;
            prevGray_q <= '0;
            ptrChg_q   <= 1'b0;
        end else begin
            syncBin_q  <= syncBin_d;
            prevGray_q <= SYNC_GRAY;
            ptrChg_q   <= ptrChg_d;
        end
    end

    // Saturating edge counter; valid rises on the edge after the chain has filled.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            validCnt_q  <= '0;
            syncValid_q <= 1'b0;
        end else begin
            if (validCnt_q != VALID_CNT_W'(STAGES)) begin
                validCnt_q <= validCnt_q + 1'b1;
            end
            if (validCnt_q == VALID_CNT_W'(STAGES)) begin
                syncValid_q <= 1'b1;
            end
        end
    end

    assign SYNC_BIN   = syncBin_q;
    assign SYNC_VALID = syncValid_q;
    assign PTR_CHG    = ptrChg_q;

    generate
        if (ERR_CHECK_EN) begin : gen_errCheck
            int unsigned hammingDist;
            logic        grayErr_d;
            logic        grayErr_q;

            assign hammingDist = popCount(PTR_WIDTH_MAX'(SYNC_GRAY ^ prevGray_q));

            // Illegal step sets the flag; a set in the same cycle as a clear wins.
            always_comb begin
                grayErr_d = grayErr_q;
                if (syncValid_q && (hammingDist > 32'd1)) begin
                    grayErr_d = 1'b1;
                end else if (ERR_CLR) begin
                    grayErr_d = 1'b0;
                end
            end

            // Sticky error register.
            always_ff @(posedge CLK or negedge RST) begin
                if (!RST) begin
                    grayErr_q <= 1'b0;
                end else begin
                    grayErr_q <= grayErr_d;
                end
            end

            assign GRAY_ERR = grayErr_q;
        end else begin : gen_noErrCheck
            assign GRAY_ERR = 1'b0;
        end
    endgenerate

endmodule
